// File: rtl/wirelog_pkg.sv
// wirelog_pkg: width helpers shared by the wire-engine blocks
package wirelog_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int trig_idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter
    import wirelog_pkg::*;
#(
    parameter int N = 2,
    localparam int W = trig_idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    always_comb begin
        int j;
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        j          = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!gnt_valid && req[j]) begin
                gnt_valid     = 1'b1;
                gnt_idx       = W'(j);
                gnt_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_trigger_dispatcher.sv
// gate_trigger_dispatcher: turns gate output changes into round-robin wire-trigger events
module gate_trigger_dispatcher
    import wirelog_pkg::*;
#(
    parameter int OUTPUT_COUNT = 2,
    localparam int IDX_W = trig_idx_w(OUTPUT_COUNT)
) (
    input  logic                    clk,
    input  logic                    logic_reset,
    input  logic [OUTPUT_COUNT-1:0] in,
    output logic                    trig_valid,
    input  logic                    trig_ready,
    output logic [IDX_W-1:0]        trig_idx,
    output logic                    busy
);

    logic [OUTPUT_COUNT-1:0] prev_q, pend_q, change, grant_mask, pend_next, gnt_onehot;
    logic [IDX_W-1:0]        rr_ptr_q, gnt_idx, ptr_next;
    logic                    gnt_valid, free, load;

    rr_arbiter #(.N(OUTPUT_COUNT)) u_arb (
        .req       (pend_q),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_onehot(gnt_onehot)
    );

    // pending bits hold toggle parity, so a double change before dispatch cancels out
    always_comb begin
        change     = in ^ prev_q;
        free       = !trig_valid || trig_ready;
        load       = free && gnt_valid;
        grant_mask = load ? gnt_onehot : '0;
        pend_next  = (pend_q & ~grant_mask) ^ change;
        ptr_next   = (gnt_idx == IDX_W'(OUTPUT_COUNT - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (logic_reset) begin
            prev_q     <= '0;
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            trig_valid <= 1'b0;
            trig_idx   <= '0;
        end else begin
            prev_q <= in;
            pend_q <= pend_next;
            if (load) begin
                trig_valid <= 1'b1;
                trig_idx   <= gnt_idx;
                rr_ptr_q   <= ptr_next;
            end else if (trig_ready) begin
                trig_valid <= 1'b0;
            end
        end
    end

    assign busy = (|pend_q) || trig_valid;

endmodule

// File: tb/tb_gate_trigger_dispatcher.sv
// tb_gate_trigger_dispatcher: directed checks of the trigger dispatcher with four outputs
module tb_gate_trigger_dispatcher;

    logic       clk = 1'b0;
    logic       logic_reset;
    logic [3:0] gin;
    logic       trig_valid, trig_ready, busy;
    logic [1:0] trig_idx;
    int         total = 0;
    int         bad   = 0;

    gate_trigger_dispatcher #(.OUTPUT_COUNT(4)) dut (
        .clk        (clk),
        .logic_reset(logic_reset),
        .in         (gin),
        .trig_valid (trig_valid),
        .trig_ready (trig_ready),
        .trig_idx   (trig_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ev(input string tag, input logic [1:0] idx);
        chk({tag, "_valid"}, 32'(trig_valid), 1);
        chk({tag, "_idx"}, 32'(trig_idx), 32'(idx));
    endtask

    task automatic idle(input string tag);
        chk({tag, "_valid"}, 32'(trig_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic reset_seq();
        logic_reset = 1'b1;
        gin         = 4'b0000;
        tick();
        logic_reset = 1'b0;
        tick();
    endtask

    initial begin
        logic_reset = 1'b1;
        gin         = 4'b0000;
        trig_ready  = 1'b0;
        // 1: reset held three cycles, nothing after release
        tick(); tick(); tick();
        idle("rst");
        chk("rst_idx", 32'(trig_idx), 0);
        logic_reset = 1'b0;
        tick(); tick();
        idle("rst_rel");

        // 2: two changes drained in order
        trig_ready = 1'b1;
        gin        = 4'b0101;
        tick();
        chk("s2_e0_valid", 32'(trig_valid), 0);
        chk("s2_e0_busy", 32'(busy), 1);
        tick(); ev("s2_e1", 2'd0);
        tick(); ev("s2_e2", 2'd2);
        tick(); idle("s2_e3");

        // 3: stall; bit1 toggles twice and cancels
        reset_seq();
        trig_ready = 1'b0;
        gin        = 4'b0001;
        tick();
        tick(); ev("s3_load", 2'd0);
        gin = 4'b0011;
        tick(); ev("s3_st1", 2'd0);
        gin = 4'b0001;
        tick(); ev("s3_st2", 2'd0);
        chk("s3_st2_busy", 32'(busy), 1);
        tick(); tick(); ev("s3_st4", 2'd0);
        trig_ready = 1'b1;
        tick(); idle("s3_acc");
        tick(); idle("s3_after");

        // 4: round-robin ordering
        reset_seq();
        trig_ready = 1'b1;
        gin        = 4'b1111;
        tick();
        tick(); ev("s4_a0", 2'd0);
        tick(); ev("s4_a1", 2'd1);
        tick(); ev("s4_a2", 2'd2);
        tick(); ev("s4_a3", 2'd3);
        tick(); idle("s4_a_end");
        gin = 4'b0110;
        tick();
        tick(); ev("s4_b0", 2'd0);
        tick(); ev("s4_b1", 2'd3);
        tick(); idle("s4_b_end");
        gin = 4'b1100;
        tick();
        tick(); ev("s4_c0", 2'd1);
        tick(); ev("s4_c1", 2'd3);
        tick(); idle("s4_c_end");

        // 5: change on the bit being granted re-arms it
        reset_seq();
        trig_ready = 1'b0;
        gin        = 4'b0100;
        tick();
        gin = 4'b0000;
        tick(); ev("s5_first", 2'd2);
        chk("s5_first_busy", 32'(busy), 1);
        tick(); ev("s5_hold", 2'd2);
        trig_ready = 1'b1;
        tick(); ev("s5_second", 2'd2);
        tick(); idle("s5_end");

        // 6: reset mid-operation discards in-flight work
        reset_seq();
        trig_ready = 1'b0;
        gin        = 4'b0100;
        tick();
        tick(); ev("s6_pre", 2'd2);
        gin = 4'b1110;
        tick();
        chk("s6_pre_busy", 32'(busy), 1);
        gin         = 4'b0110;
        logic_reset = 1'b1;
        tick(); idle("s6_rst");
        chk("s6_rst_idx", 32'(trig_idx), 0);
        logic_reset = 1'b0;
        trig_ready  = 1'b1;
        tick();
        chk("s6_r0_valid", 32'(trig_valid), 0);
        chk("s6_r0_busy", 32'(busy), 1);
        tick(); ev("s6_r1", 2'd1);
        tick(); ev("s6_r2", 2'd2);
        tick(); idle("s6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
